// File: rtl/dt_pkg.sv
// Shared definitions for the CAN-bus decision-tree classifier.
// Contents:
//   - node-word field positions
//   - feature count and widths
//   - traversal state enum
//   - error class code
//   - feature-select helper
package dt_pkg;

   // Node word field positions (bit indices into the 64-bit node word)
   localparam int LEAF_BIT   = 63;
   localparam int FEAT_MSB   = 55;
   localparam int FEAT_LSB   = 53;
   localparam int THR_MSB    = 52;
   localparam int THR_LSB    = 26;
   localparam int RCHILD_MSB = 25;
   localparam int RCHILD_LSB = 18;
   localparam int LCHILD_MSB = 17;
   localparam int LCHILD_LSB = 10;
   localparam int CLASS_MSB  = 7;
   localparam int CLASS_LSB  = 0;

   localparam int NUM_FEATURES = 6;
   localparam int FEAT_W       = 32;
   localparam int THR_W        = 27;

   // Class label reported when a run aborts
   localparam logic [7:0] ERR_CLASS = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EVAL  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Pick feature k out of the packed feature vector.
   // Ids 6 and 7 have no feature; they return zero and the caller aborts.
   function automatic logic [FEAT_W-1:0] feature_select(
      input logic [NUM_FEATURES*FEAT_W-1:0] feats,
      input logic [2:0]                     fid
   );
      logic [FEAT_W-1:0] sel;
      case (fid)
         3'd0:    sel = feats[  0 +: FEAT_W];
         3'd1:    sel = feats[ 32 +: FEAT_W];
         3'd2:    sel = feats[ 64 +: FEAT_W];
         3'd3:    sel = feats[ 96 +: FEAT_W];
         3'd4:    sel = feats[128 +: FEAT_W];
         3'd5:    sel = feats[160 +: FEAT_W];
         default: sel = {FEAT_W{1'b0}};
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/threshold_decoder.sv
// Per-node threshold comparator.
// Ports:
//   feature_id        : in, node feature id
//   threshold         : in, node threshold (27 bits)
//   feature           : in, selected latched feature value (32 bits)
//   comparison_result : out, 1 when the feature goes to the left child
// Feature and threshold already share one fixed-point format, so the
// compare is a plain unsigned 32-bit one against the zero-extended
// threshold. Equal values go left.
module threshold_decoder
   import dt_pkg::*;
(
   input  logic [2:0]        feature_id,
   input  logic [THR_W-1:0]  threshold,
   input  logic [FEAT_W-1:0] feature,
   output logic              comparison_result
);

   // Unsigned compare, forced low for ids that do not name a feature
   always_comb begin
      comparison_result = 1'b0;
      if (feature_id < 3'(NUM_FEATURES)) begin
         comparison_result = (feature <= {5'b0, threshold});
      end else begin
         comparison_result = 1'b0;
      end
   end

endmodule

// File: rtl/tree_traversal_ctrl.sv
// Decision-tree traversal controller.
// Walks node memory from ROOT_ADDR, one node per FETCH/EVAL pair, until
// it reaches a leaf, hits a bad feature id, or exhausts MAX_DEPTH.
// Ports:
//   clk, rst_n : clock; synchronous active-low reset
//   start      : in, request (taken only while ready)
//   features   : in, 6 x 32-bit features, latched on acceptance
//   ready      : out, idle
//   mem_rd_en  : out, node read strobe (high in FETCH)
//   mem_addr   : out, node address (doubles as the walk pointer)
//   mem_rdata  : in, node word, valid one cycle after mem_rd_en
//   done       : out, one-cycle result pulse
//   class_out  : out, leaf class label, or ERR_CLASS on abort
//   error      : out, last run aborted
//   depth      : out, number of nodes visited in the last run
module tree_traversal_ctrl
   import dt_pkg::*;
#(
   parameter logic [7:0] ROOT_ADDR = 8'd0,
   parameter int         MAX_DEPTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [NUM_FEATURES*FEAT_W-1:0] features,
   output logic                           ready,
   output logic                           mem_rd_en,
   output logic [7:0]                     mem_addr,
   input  logic [63:0]                    mem_rdata,
   output logic                           done,
   output logic [7:0]                     class_out,
   output logic                           error,
   output logic [5:0]                     depth
);

   state_t                           state_r;
   logic [NUM_FEATURES*FEAT_W-1:0]   feat_r;

   // Node word fields (mem_rdata is only meaningful in EVAL)
   logic              node_leaf_s;
   logic [2:0]        node_fid_s;
   logic [THR_W-1:0]  node_thr_s;
   logic [7:0]        node_right_s;
   logic [7:0]        node_left_s;
   logic [7:0]        node_class_s;
   logic [FEAT_W-1:0] sel_feature_s;
   logic              go_left_s;
   logic              unused_bits_s;

   assign node_leaf_s   = mem_rdata[LEAF_BIT];
   assign node_fid_s    = mem_rdata[FEAT_MSB:FEAT_LSB];
   assign node_thr_s    = mem_rdata[THR_MSB:THR_LSB];
   assign node_right_s  = mem_rdata[RCHILD_MSB:RCHILD_LSB];
   assign node_left_s   = mem_rdata[LCHILD_MSB:LCHILD_LSB];
   assign node_class_s  = mem_rdata[CLASS_MSB:CLASS_LSB];
   assign unused_bits_s = ^{mem_rdata[62:56], mem_rdata[9:8]};

   assign sel_feature_s = feature_select(feat_r, node_fid_s);

   threshold_decoder u_cmp (
      .feature_id        (node_fid_s),
      .threshold         (node_thr_s),
      .feature           (sel_feature_s),
      .comparison_result (go_left_s)
   );

   // Traversal FSM with all outputs registered.
   // mem_addr is the walk pointer; it only moves when entering FETCH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         feat_r    <= '0;
         ready     <= 1'b1;
         mem_rd_en <= 1'b0;
         mem_addr  <= ROOT_ADDR;
         done      <= 1'b0;
         class_out <= 8'd0;
         error     <= 1'b0;
         depth     <= 6'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done      <= 1'b0;
               mem_rd_en <= 1'b0;
               if (start) begin
                  feat_r    <= features;
                  mem_addr  <= ROOT_ADDR;
                  error     <= 1'b0;
                  depth     <= 6'd0;
                  ready     <= 1'b0;
                  mem_rd_en <= 1'b1;
                  state_r   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               mem_rd_en <= 1'b0;
               depth     <= depth + 6'd1;
               state_r   <= ST_EVAL;
            end
            ST_EVAL: begin
               // Priority: leaf, then bad feature id, then depth budget
               if (node_leaf_s) begin
                  class_out <= node_class_s;
                  done      <= 1'b1;
                  state_r   <= ST_DONE;
               end else if (node_fid_s >= 3'(NUM_FEATURES)) begin
                  error     <= 1'b1;
                  class_out <= ERR_CLASS;
                  done      <= 1'b1;
                  state_r   <= ST_DONE;
               end else if (depth == 6'(MAX_DEPTH)) begin
                  error     <= 1'b1;
                  class_out <= ERR_CLASS;
                  done      <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  mem_addr  <= go_left_s ? node_left_s : node_right_s;
                  mem_rd_en <= 1'b1;
                  state_r   <= ST_FETCH;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               ready   <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               done      <= 1'b0;
               mem_rd_en <= 1'b0;
               ready     <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tree_traversal_ctrl.sv
// Scoreboard bench for tree_traversal_ctrl.
// An acceptance observer pushes the reference-model result for every
// accepted start. A done monitor pops the result and compares it.
module tb_tree_traversal_ctrl;

   localparam int MAX_D = 32;
   localparam int ROOT  = 0;

   typedef struct packed {
      logic [7:0] cls;
      logic       err;
      logic [5:0] dep;
      int         acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [191:0] features = '0;
   logic         ready;
   logic         mem_rd_en;
   logic [7:0]   mem_addr;
   logic [63:0]  mem_rdata = '0;
   logic         done;
   logic [7:0]   class_out;
   logic         error;
   logic [5:0]   depth;

   logic [63:0]  node_mem [256];
   exp_t         sb_q[$];
   int           acc_log[$];
   exp_t         last;
   bit           have_last = 1'b0;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;

   tree_traversal_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .features  (features),
      .ready     (ready),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .done      (done),
      .class_out (class_out),
      .error     (error),
      .depth     (depth)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Build a node word with random junk in every field the walk should ignore
   function automatic logic [63:0] mk_node(logic leaf, logic [2:0] fid, logic [26:0] thr,
                                           logic [7:0] r, logic [7:0] l, logic [7:0] cls);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[63] = leaf; w[55:53] = fid; w[52:26] = thr;
      w[25:18] = r; w[17:10] = l; w[7:0] = cls;
      return w;
   endfunction

   // Reference walk: follow the tree rules directly on the memory array
   function automatic exp_t ref_walk(logic [191:0] f, int acc);
      exp_t e;
      int addr;
      logic [63:0] w;
      logic [31:0] fv;
      e.cls = 8'hFF; e.err = 1'b1; e.dep = 6'd0; e.acc = acc;
      addr = ROOT;
      for (int d = 1; d <= MAX_D; d++) begin
         w = node_mem[addr];
         if (w[63]) begin
            e.cls = w[7:0]; e.err = 1'b0; e.dep = 6'(d); return e;
         end
         if (w[55:53] > 3'd5 || d == MAX_D) begin
            e.cls = 8'hFF; e.err = 1'b1; e.dep = 6'(d); return e;
         end
         fv = f[int'(w[55:53])*32 +: 32];
         addr = (fv <= {5'b0, w[52:26]}) ? int'(w[17:10]) : int'(w[25:18]);
      end
      return e;
   endfunction

   // Single-cycle-latency node memory
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= node_mem[mem_addr];
   end

   // Acceptance observer: predict the result and check the held outputs
   always @(posedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         have_last = 1'b0;
      end else if (start && ready) begin
         if (have_last) begin
            chk("hold_class", 64'(class_out), 64'(last.cls));
            chk("hold_error", 64'(error), 64'(last.err));
            chk("hold_depth", 64'(depth), 64'(last.dep));
         end
         sb_q.push_back(ref_walk(features, cyc));
         acc_log.push_back(cyc);
      end
      cyc = cyc + 1;
   end

   // Done monitor: pop and compare
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("class_out", 64'(class_out), 64'(e.cls));
            chk("error", 64'(error), 64'(e.err));
            chk("depth", 64'(depth), 64'(e.dep));
            chk("done_latency", 64'(cyc), 64'(e.acc + 2 * int'(e.dep) + 1));
            last = e;
            have_last = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(ready === 1'b1 && sb_q.size() == 0) && n < 300) begin
         @(negedge clk); n++;
      end
      if (n >= 300) begin
         tests++; fails++;
         $display("FAIL idle_timeout: got not idle expected idle within 300 cycles");
      end
   endtask

   task automatic run_one(logic [191:0] f);
      wait_idle();
      features = f;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   function automatic logic [191:0] rnd_feats();
      logic [191:0] f;
      for (int k = 0; k < 6; k++) begin
         f[k*32 +: 32] = $urandom & (($urandom_range(0, 1) == 0) ? 32'h07FF_FFFF : 32'hFFFF_FFFF);
      end
      return f;
   endfunction

   task automatic build_two_leaf_tree();
      node_mem[0] = mk_node(1'b0, 3'd0, 27'h0010000, 8'd2, 8'd1, 8'd0);
      node_mem[1] = mk_node(1'b1, 3'd0, 27'd0, 8'd0, 8'd0, 8'd1);
      node_mem[2] = mk_node(1'b1, 3'd0, 27'd0, 8'd0, 8'd0, 8'd2);
   endtask

   initial begin
      logic [191:0] f;
      int c0;
      int n;
      for (int i = 0; i < 256; i++) node_mem[i] = 64'h8000_0000_0000_0000;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_class", 64'(class_out), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_depth", 64'(depth), 64'd0);
      rst_n = 1'b1;

      // Root is a leaf
      node_mem[0] = mk_node(1'b1, 3'd0, 27'd0, 8'd0, 8'd0, 8'h03);
      run_one(rnd_feats());
      chk("leaf_class", 64'(class_out), 64'h03);
      chk("leaf_depth", 64'(depth), 64'd1);

      // One compare: equal goes left, one above goes right
      build_two_leaf_tree();
      f = rnd_feats(); f[31:0] = 32'h0001_0000;
      run_one(f);
      chk("eq_left_class", 64'(class_out), 64'd1);
      chk("eq_left_depth", 64'(depth), 64'd2);
      f[31:0] = 32'h0001_0001;
      run_one(f);
      chk("gt_right_class", 64'(class_out), 64'd2);

      // Bad feature id at the root
      node_mem[0] = mk_node(1'b0, 3'd7, 27'd5, 8'd1, 8'd1, 8'd0);
      run_one(rnd_feats());
      chk("fid7_error", 64'(error), 64'd1);
      chk("fid7_class", 64'(class_out), 64'hFF);
      chk("fid7_depth", 64'(depth), 64'd1);

      // Self loop terminates on the depth budget
      node_mem[0] = mk_node(1'b0, 3'd0, 27'h123, 8'd0, 8'd0, 8'd0);
      run_one(rnd_feats());
      chk("loop_error", 64'(error), 64'd1);
      chk("loop_depth", 64'(depth), 64'd32);

      // Reset in the EVAL of the second node discards the run
      build_two_leaf_tree();
      acc_log.delete();
      features = rnd_feats(); start = 1'b1;
      @(negedge clk); start = 1'b0;
      if (acc_log.size() != 1) begin
         tests++; fails++;
         $display("FAIL rst_mid_accept: got %0d accepts expected 1", acc_log.size());
         c0 = cyc - 1;
      end else begin
         c0 = acc_log[0];
      end
      while (cyc < c0 + 4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 64'(ready), 64'd1);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_rd_en", 64'(mem_rd_en), 64'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      f = rnd_feats(); f[31:0] = 32'h0000_0005;
      run_one(f);
      chk("after_rst_class", 64'(class_out), 64'd1);

      // Start held high with features changing mid-run
      acc_log.delete();
      f = rnd_feats(); f[31:0] = 32'h0001_0000;
      features = f; start = 1'b1;
      n = 0;
      while (acc_log.size() < 2 && n < 100) begin
         @(negedge clk); n++;
         if (acc_log.size() >= 2) break;
         f = rnd_feats(); f[31:0] = 32'h0001_0001;
         features = f;
      end
      start = 1'b0;
      if (acc_log.size() < 2) begin
         tests++; fails++;
         $display("FAIL held_start: got %0d accepts expected 2", acc_log.size());
      end else begin
         chk("held_gap", 64'(acc_log[1] - acc_log[0]), 64'd6);
      end
      wait_idle();
      chk("held_second_class", 64'(class_out), 64'd2);

      // Random trees
      for (int it = 0; it < 40; it++) begin
         if (it % 8 == 0) begin
            for (int a = 0; a < 16; a++) begin
               node_mem[a] = mk_node(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                                     ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                                 : 3'($urandom_range(0, 5)),
                                     27'($urandom), 8'($urandom_range(0, 15)),
                                     8'($urandom_range(0, 15)), 8'($urandom));
            end
         end
         run_one(rnd_feats());
      end

      wait_idle();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tree_traversal_ctrl.md
# tree_traversal_ctrl

Sequencing controller for the CAN-bus decision-tree classifier. It accepts a frame's six scaled feature values and walks the node memory from the root, one node at a time. At each internal node it evaluates the node's threshold compare and follows the left or right child pointer. At a leaf it returns the class label. It sits between the feature-extraction stage and the classification output, owns the node-memory read port, and instantiates the single per-node comparator.

## Interface
- `ROOT_ADDR`, default 8'd0: node-memory address of the tree root.
- `MAX_DEPTH`, default 32: maximum number of nodes visited before abort.
- Reset and clock: one clock; reset is synchronous and active-low.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request a classification; accepted only when `ready`=1.
- `features`, input, 192: six 32-bit features; feature k is bits [32k+31:32k]. Sampled on acceptance.
- `ready`, output, 1: block is idle and can accept `start`.
- `mem_rd_en`, output, 1: node-memory read strobe.
- `mem_addr`, output, 8: node address.
- `mem_rdata`, input, 64: node word, valid on the cycle after `mem_rd_en`.
- `done`, output, 1: one-cycle pulse when a result is available.
- `class_out`, output, 8: leaf class label; held until the next acceptance.
- `error`, output, 1: last run aborted; held until the next acceptance.
- `depth`, output, 6: number of nodes visited in the last run.

## Operation
Node word layout:
- bit 63: leaf flag.
- [55:53]: feature_id.
- [52:26]: 27-bit threshold.
- [25:18]: right child.
- [17:10]: left child.
- [7:0]: class label, meaningful only when the leaf flag is set.
- All other bits are ignored.

State machine states are IDLE, FETCH, EVAL and DONE.
- **IDLE** (`ready`=1): on `start`=1, latch `features` into a 192-bit register, set the address register to `ROOT_ADDR`, clear `error` and `depth`, then go to FETCH.
- **FETCH**: drive `mem_rd_en`=1 with `mem_addr` equal to the address register, increment `depth`, then go to EVAL.
- **EVAL**: `mem_rdata` is valid in this state.
  - Leaf flag set: `class_out` = [7:0], go to DONE.
  - feature_id of 6 or 7: `error`=1, `class_out`=8'hFF, go to DONE.
  - `depth` equal to `MAX_DEPTH` at a non-leaf node: `error`=1, `class_out`=8'hFF, go to DONE.
  - Otherwise: go_left = latched feature[feature_id] <= {5'b0, threshold}, compared as unsigned 32-bit. The address register takes the left child if go_left, else the right child. Go to FETCH.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Comparison arithmetic: no per-feature rescaling. Feature values arrive already in the threshold's fixed-point format for that feature (Q11.16, Q4.23, Q8.19, Q8.19, Q11.16 and Q0.27 for features 0 to 5).
- Child pointers are not range-checked. A self-loop or cycle in the tree terminates through the `MAX_DEPTH` abort.
- `start` is ignored outside IDLE, and `features` is not re-sampled mid-run.

## Timing
- Reset values: state IDLE, `ready`=1, `mem_rd_en`=0, `mem_addr`=`ROOT_ADDR`, `done`=0, `class_out`=0, `error`=0, `depth`=0.
- Reset asserted mid-run returns to IDLE on the next edge and discards the run. No `done` is produced.
- Memory read latency is exactly 1 cycle. `mem_addr` holds its value outside FETCH.
- Each visited node costs 2 cycles (FETCH, EVAL).
- For a path of n internal nodes ending at a leaf, with `start` accepted at edge 0:
  - `done` is high in cycle 2(n+1)+1.
  - `ready` returns in the following cycle.
  - The earliest back-to-back start is accepted 2n+4 cycles apart.
- `class_out`, `error` and `depth` are registered. They are stable from the `done` cycle until the next accepted `start`.

## Structure
- Shared package `dt_pkg` holds:
  - node field bit positions (LEAF_BIT, FEAT_MSB/LSB, THR_MSB/LSB, RCHILD_MSB/LSB, LCHILD_MSB/LSB, CLASS_MSB/LSB);
  - NUM_FEATURES=6;
  - the state enum;
  - the error class code 8'hFF.
- One sub-module: the existing `threshold_decoder` comparator, instantiated once. Inputs are feature_id, threshold and the muxed latched feature; `comparison_result` is used as go_left.
- Feature mux, FSM, depth counter and result registers live in this block.

## Test plan
- Root at 0 is a leaf with class 8'h03 -> `done` in cycle 3 after acceptance; `class_out`=3, `depth`=1, `error`=0.
- Root: feature 0, threshold 27'h0010000, left child 1 (leaf, class 1), right child 2 (leaf, class 2). Feature0=32'h00010000 -> class 1, since equal goes left. Feature0=32'h00010001 -> class 2. `done` in cycle 5, `depth`=2.
- Root uses feature_id 7 -> `error`=1, `class_out`=8'hFF, `depth`=1.
- Node 0 is non-leaf with both children pointing to 0, `MAX_DEPTH`=32 -> abort with `error`=1, `depth`=32, `done` in cycle 65.
- `rst_n` driven low in the EVAL of the second node -> IDLE next edge, `ready`=1, no `done`. A new `start` then completes normally.
- `start` held high throughout and during a run with different `features` -> no effect until `ready`. The result reflects the first sampled features, and a second run starts in the cycle after `done`+1.
